instr_stream_encoder: RTL and testbench
=======================================

Name: instr_stream_encoder

Overview:
- Inverse of the CPU control decoder: accepts symbolic operations and encodes each into a 32-bit LEGv8-subset instruction word.
- Writes each word sequentially into instruction memory during program load, before the pipelined CPU is released.
- Resolves PC-relative branch offsets from absolute word targets and counts emitted words.
- Sits between the testbench or loader front-end and the instruction-memory write port.

Parameters:
- AW, 10, word-address width of instruction memory (AW ≤ 19).
- DEPTH, 1024, number of writable words, starting at base_addr.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  pulse: latch base_addr, clear count and error flags, enter RUN.
- base_addr  in  AW  first word address.
- finish  in  1  pulse: end of program.
- in_valid  in  1  operation valid.
- in_ready  out  1  encoder can accept an operation.
- in_op  in  4  operation code (enum, see Behaviour).
- in_rd, in_rn, in_rm  in  5 each  register fields (in_rd also carries Rt).
- in_imm  in  12  imm12 (ADDI), low 9 bits DAddr9 (LDUR/STUR), low 6 bits shamt (LSL/LSR).
- in_target  in  AW  absolute word address for B/CBZ/BLT.
- mem_we  out  1  instruction-memory write strobe.
- mem_addr  out  AW  write address.
- mem_wdata  out  32  encoded word.
- busy  out  1  state is RUN or PAD.
- done  out  1  state is DONE.
- count  out  AW+1  words written since start.
- err_op, err_full  out  1 each  sticky error flags.

Behaviour:
- Reset: state=IDLE. All outputs 0: in_ready, mem_we, mem_addr, mem_wdata, busy, done, count, err_op, err_full.
- States:
  - IDLE –start→ RUN.
  - RUN –finish→ PAD if HALT_PAD_EN is defined, else DONE.
  - PAD → DONE after one cycle.
  - DONE –start→ RUN.
  - start is ignored in RUN and PAD.
- Handshake:
  - in_ready = (state==RUN) && (count<DEPTH).
  - An op is accepted on a cycle with in_valid && in_ready.
  - If in_valid and finish are both high in the same cycle, the op is accepted and the state then advances.
- Latency: an op accepted in cycle N produces mem_we=1 in cycle N+1. mem_addr = base_addr+count as sampled at acceptance; count increments in cycle N+1.
- mem_we is a single-cycle pulse. mem_addr and mem_wdata hold their values between writes.
- Encodings (field bit positions):
  - NOP (0): 0x910003FF, i.e. ADDI X31,X31,#0.
  - ADDI (1): 1001000100 | imm12[21:10] | Rn | Rd.
  - ADDS (2): 10101011000 | Rm | shamt=0 | Rn | Rd.
  - SUBS (3): 11101011000 | Rm | shamt=0 | Rn | Rd.
  - B (4): 000101 | imm26.
  - CBZ (5): 10110100 | imm19 | Rt.
  - BLT (6): 01010100 | imm19 | 5'b01011.
  - LDUR (7): 11111000010 | DAddr9[20:12] | 00 | Rn | Rt.
  - STUR (8): 11111000000 | DAddr9[20:12] | 00 | Rn | Rt.
  - LSL (9): 11010011011 | Rm=0 | shamt | Rn | Rd.
  - LSR (10): 11010011010 | Rm=0 | shamt | Rn | Rd.
  - MUL (11): 10011011000 | Rm | 011111 | Rn | Rd.
- Branch offset = in_target − write address, as a two's-complement word count, sign-extended to 19 or 26 bits.
- Ops 12–15: accepted, nothing written, count unchanged, err_op set.
- Full: count==DEPTH deasserts in_ready. An in_valid held while full sets err_full. finish while full skips PAD and sets err_full.
- Reset asserted mid-RUN abandons any pending write; no mem_we is issued on the following cycle.

Optional Feature:
- Macro: HALT_PAD_EN.
- Defined: in PAD, write 0x14000000 (B +0, a self-loop halt) at the next address, increment count, then go to DONE.
- Undefined: finish goes directly to DONE and no extra word is written.

Decomposition:
- Package instr_enc_pkg holds:
  - op_t enum.
  - 11-, 10-, 8- and 6-bit opcode constants.
  - NOP_WORD, HALT_WORD, COND_LT.
  - State enum.
- Sub-module instr_field_pack: purely combinational (op, fields, offset) → 32-bit word. The parent owns the FSM, pointer and register stage.

Test Plan:
- Reset then start with base_addr=0; ADDI rd=1 rn=2 imm=5 → next cycle mem_we=1, mem_addr=0, mem_wdata=0x91001441, count=1.
- STUR rt=4 rn=5 imm=8 at addr 1 → 0xF80080A4. Then NOP → 0x910003FF at addr 2.
- Ops written at addr 4: CBZ rt=3 target=2 → 0xB4FFFFC3. Then BLT from addr 5, target=8 → 0x5400006B.
- DEPTH=4, five back-to-back ops → exactly 4 writes, in_ready=0 after the 4th acceptance, err_full=1, count=4.
- in_op=13 → no mem_we, err_op=1, count unchanged. finish with HALT_PAD_EN defined → 0x14000000 written at next address, done=1. With the macro undefined → no write, done=1.
- Reset asserted the cycle after an accept → mem_we=0, count=0, state IDLE.

Source files
------------

// File: rtl/instr_enc_pkg.sv
// rtl/instr_enc_pkg.sv - op codes, opcode fields, fixed words and FSM states for the encoder

package instr_enc_pkg;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_ADDI = 4'd1,
        OP_ADDS = 4'd2,
        OP_SUBS = 4'd3,
        OP_B    = 4'd4,
        OP_CBZ  = 4'd5,
        OP_BLT  = 4'd6,
        OP_LDUR = 4'd7,
        OP_STUR = 4'd8,
        OP_LSL  = 4'd9,
        OP_LSR  = 4'd10,
        OP_MUL  = 4'd11
    } op_t;

    localparam logic [10:0] OPC11_ADDS = 11'b10101011000;
    localparam logic [10:0] OPC11_SUBS = 11'b11101011000;
    localparam logic [10:0] OPC11_LDUR = 11'b11111000010;
    localparam logic [10:0] OPC11_STUR = 11'b11111000000;
    localparam logic [10:0] OPC11_LSL  = 11'b11010011011;
    localparam logic [10:0] OPC11_LSR  = 11'b11010011010;
    localparam logic [10:0] OPC11_MUL  = 11'b10011011000;
    localparam logic [9:0]  OPC10_ADDI = 10'b1001000100;
    localparam logic [7:0]  OPC8_CBZ   = 8'b10110100;
    localparam logic [7:0]  OPC8_BCOND = 8'b01010100;
    localparam logic [5:0]  OPC6_B     = 6'b000101;

    localparam logic [31:0] NOP_WORD  = 32'h910003FF;
    localparam logic [31:0] HALT_WORD = 32'h14000000;
    localparam logic [4:0]  COND_LT   = 5'b01011;
    localparam logic [5:0]  MUL_RA    = 6'b011111;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_PAD  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/instr_field_pack.sv
// rtl/instr_field_pack.sv - combinational packing of one symbolic op into a 32-bit instruction word

module instr_field_pack
    import instr_enc_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [4:0]  rd,
    input  logic [4:0]  rn,
    input  logic [4:0]  rm,
    input  logic [11:0] imm,
    input  logic [25:0] offset,
    output logic [31:0] word,
    output logic        op_valid
);

    always_comb begin
        word     = 32'h0;
        op_valid = 1'b1;
        case (op)
            OP_NOP:  word = NOP_WORD;
            OP_ADDI: word = {OPC10_ADDI, imm, rn, rd};
            OP_ADDS: word = {OPC11_ADDS, rm, 6'd0, rn, rd};
            OP_SUBS: word = {OPC11_SUBS, rm, 6'd0, rn, rd};
            OP_B:    word = {OPC6_B, offset};
            OP_CBZ:  word = {OPC8_CBZ, offset[18:0], rd};
            OP_BLT:  word = {OPC8_BCOND, offset[18:0], COND_LT};
            OP_LDUR: word = {OPC11_LDUR, imm[8:0], 2'b00, rn, rd};
            OP_STUR: word = {OPC11_STUR, imm[8:0], 2'b00, rn, rd};
            OP_LSL:  word = {OPC11_LSL, 5'd0, imm[5:0], rn, rd};
            OP_LSR:  word = {OPC11_LSR, 5'd0, imm[5:0], rn, rd};
            OP_MUL:  word = {OPC11_MUL, rm, MUL_RA, rn, rd};
            default: op_valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_stream_encoder.sv
// rtl/instr_stream_encoder.sv - loads encoded instruction words into imem; HALT_PAD_EN appends a halt word

module instr_stream_encoder
    import instr_enc_pkg::*;
#(
    parameter int AW    = 10,
    parameter int DEPTH = 1024
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic          finish,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    in_op,
    input  logic [4:0]    in_rd,
    input  logic [4:0]    in_rn,
    input  logic [4:0]    in_rm,
    input  logic [11:0]   in_imm,
    input  logic [AW-1:0] in_target,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic          busy,
    output logic          done,
    output logic [AW:0]   count,
    output logic          err_op,
    output logic          err_full
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_C   = (AW+1)'(1);

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] base_q, base_d;
    logic [AW:0]   count_q, count_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic          err_op_q, err_op_d;
    logic          err_full_q, err_full_d;

    logic          full;
    logic          accept;
    logic [AW-1:0] wr_addr;
    logic [AW:0]   diff;
    logic [25:0]   offset;
    logic [31:0]   enc_word;
    logic          enc_valid;

    assign full    = (count_q >= DEPTH_C);
    assign wr_addr = base_q + count_q[AW-1:0];
    assign in_ready = (state_q == ST_RUN) && !full;
    assign accept   = in_valid && in_ready;

    // One extra bit keeps the target-minus-address difference exact before sign extension
    assign diff   = {1'b0, in_target} - {1'b0, wr_addr};
    assign offset = {{(26-AW-1){diff[AW]}}, diff};

    instr_field_pack u_pack (
        .op       (in_op),
        .rd       (in_rd),
        .rn       (in_rn),
        .rm       (in_rm),
        .imm      (in_imm),
        .offset   (offset),
        .word     (enc_word),
        .op_valid (enc_valid)
    );

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        count_d     = count_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        err_op_d    = err_op_q;
        err_full_d  = err_full_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d    = ST_RUN;
                    base_d     = base_addr;
                    count_d    = '0;
                    err_op_d   = 1'b0;
                    err_full_d = 1'b0;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    if (enc_valid) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = wr_addr;
                        mem_wdata_d = enc_word;
                        count_d     = count_q + ONE_C;
                    end else begin
                        err_op_d = 1'b1;
                    end
                end
                if (in_valid && full) err_full_d = 1'b1;
                if (finish) begin
                    if (full) begin
                        err_full_d = 1'b1;
                        state_d    = ST_DONE;
                    end else begin
`ifdef HALT_PAD_EN
                        state_d = ST_PAD;
`else
                        state_d = ST_DONE;
`endif
                    end
                end
            end
            ST_PAD: begin
                // The op accepted alongside finish may have filled the last slot
                if (!full) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = wr_addr;
                    mem_wdata_d = HALT_WORD;
                    count_d     = count_q + ONE_C;
                end else begin
                    err_full_d = 1'b1;
                end
                state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            base_q      <= '0;
            count_q     <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            err_op_q    <= 1'b0;
            err_full_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            count_q     <= count_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            err_op_q    <= err_op_d;
            err_full_q  <= err_full_d;
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = (state_q == ST_RUN) || (state_q == ST_PAD);
    assign done      = (state_q == ST_DONE);
    assign count     = count_q;
    assign err_op    = err_op_q;
    assign err_full  = err_full_q;

endmodule

// File: tb/tb_instr_stream_encoder.sv
// tb/tb_instr_stream_encoder.sv - directed vectors for instr_stream_encoder (DEPTH=4), HALT_PAD_EN aware

module tb_instr_stream_encoder;

    localparam int AW    = 10;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] base_addr;
    logic          finish;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_op;
    logic [4:0]    in_rd, in_rn, in_rm;
    logic [11:0]   in_imm;
    logic [AW-1:0] in_target;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          busy, done;
    logic [AW:0]   count;
    logic          err_op, err_full;

    int vectors  = 0;
    int failures = 0;

    always #5 clk = ~clk;

    instr_stream_encoder #(.AW(AW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .finish    (finish),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_rd     (in_rd),
        .in_rn     (in_rn),
        .in_rm     (in_rm),
        .in_imm    (in_imm),
        .in_target (in_target),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .count     (count),
        .err_op    (err_op),
        .err_full  (err_full)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rn,
                          input logic [4:0] rm, input logic [11:0] imm, input logic [AW-1:0] tgt);
        in_valid  = 1'b1;
        in_op     = op;
        in_rd     = rd;
        in_rn     = rn;
        in_rm     = rm;
        in_imm    = imm;
        in_target = tgt;
    endtask

    task automatic check_write(input string tag, input logic [AW-1:0] addr,
                               input logic [31:0] word, input logic [AW:0] cnt);
        check({tag, "_we"},    32'(mem_we),    32'd1);
        check({tag, "_addr"},  32'(mem_addr),  32'(addr));
        check({tag, "_wdata"}, mem_wdata,      word);
        check({tag, "_count"}, 32'(count),     32'(cnt));
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; base_addr = '0; finish = 1'b0;
        in_valid = 1'b0; in_op = '0; in_rd = '0; in_rn = '0; in_rm = '0;
        in_imm = '0; in_target = '0;
        step();
        step();
        check("rst_in_ready", 32'(in_ready),  32'd0);
        check("rst_mem_we",   32'(mem_we),    32'd0);
        check("rst_mem_addr", 32'(mem_addr),  32'd0);
        check("rst_wdata",    mem_wdata,      32'd0);
        check("rst_busy",     32'(busy),      32'd0);
        check("rst_done",     32'(done),      32'd0);
        check("rst_count",    32'(count),     32'd0);
        check("rst_err_op",   32'(err_op),    32'd0);
        check("rst_err_full", 32'(err_full),  32'd0);

        // Program 1 at base 0: fill all four words, then push a fifth op
        reset = 1'b0; start = 1'b1; base_addr = 10'd0;
        step();
        start = 1'b0;
        check("p1_busy",     32'(busy),     32'd1);
        check("p1_in_ready", 32'(in_ready), 32'd1);
        check("p1_count",    32'(count),    32'd0);

        set_op(4'd1, 5'd1, 5'd2, 5'd0, 12'd5, 10'd0);
        step();
        check_write("addi", 10'd0, 32'h91001441, 11'd1);

        set_op(4'd8, 5'd4, 5'd5, 5'd0, 12'd8, 10'd0);
        step();
        check_write("stur", 10'd1, 32'hF80080A4, 11'd2);

        set_op(4'd0, 5'd0, 5'd0, 5'd0, 12'd0, 10'd0);
        step();
        check_write("nop", 10'd2, 32'h910003FF, 11'd3);

        set_op(4'd4, 5'd0, 5'd0, 5'd0, 12'd0, 10'd0);
        step();
        check_write("b_back3", 10'd3, 32'h17FFFFFD, 11'd4);
        check("full_in_ready", 32'(in_ready), 32'd0);

        set_op(4'd11, 5'd1, 5'd2, 5'd3, 12'd0, 10'd0);
        step();
        check("full_mem_we",   32'(mem_we),   32'd0);
        check("full_err_full", 32'(err_full), 32'd1);
        check("full_count",    32'(count),    32'd4);
        check("full_addr_hold", 32'(mem_addr), 32'd3);

        in_valid = 1'b0; finish = 1'b1;
        step();
        finish = 1'b0;
        check("fin_full_done",  32'(done),     32'd1);
        check("fin_full_busy",  32'(busy),     32'd0);
        check("fin_full_we",    32'(mem_we),   32'd0);
        check("fin_full_count", 32'(count),    32'd4);

        // Program 2 at base 4: branches, an illegal op, and finish with an op
        start = 1'b1; base_addr = 10'd4;
        step();
        start = 1'b0;
        check("p2_count",    32'(count),    32'd0);
        check("p2_err_full", 32'(err_full), 32'd0);
        check("p2_busy",     32'(busy),     32'd1);

        set_op(4'd5, 5'd3, 5'd0, 5'd0, 12'd0, 10'd2);
        step();
        check_write("cbz", 10'd4, 32'hB4FFFFC3, 11'd1);

        set_op(4'd6, 5'd0, 5'd0, 5'd0, 12'd0, 10'd8);
        step();
        check_write("blt", 10'd5, 32'h5400006B, 11'd2);

        set_op(4'd13, 5'd1, 5'd1, 5'd1, 12'd1, 10'd0);
        step();
        check("bad_mem_we",     32'(mem_we),    32'd0);
        check("bad_err_op",     32'(err_op),    32'd1);
        check("bad_count",      32'(count),     32'd2);
        check("bad_addr_hold",  32'(mem_addr),  32'd5);
        check("bad_wdata_hold", mem_wdata,      32'h5400006B);

        set_op(4'd9, 5'd7, 5'd8, 5'd0, 12'd4, 10'd0);
        finish = 1'b1;
        step();
        in_valid = 1'b0; finish = 1'b0;
        check_write("lsl_fin", 10'd6, 32'hD3601107, 11'd3);
`ifdef HALT_PAD_EN
        check("pad_busy", 32'(busy), 32'd1);
        check("pad_done", 32'(done), 32'd0);
        step();
        check("halt_done", 32'(done), 32'd1);
        check_write("halt", 10'd7, 32'h14000000, 11'd4);
`else
        check("nopad_done", 32'(done), 32'd1);
        step();
        check("nopad_mem_we", 32'(mem_we), 32'd0);
        check("nopad_count",  32'(count),  32'd3);
        check("nopad_done2",  32'(done),   32'd1);
`endif

        // Program 3: reset lands the cycle after an accept
        start = 1'b1; base_addr = 10'd0;
        step();
        start = 1'b0;
        set_op(4'd1, 5'd1, 5'd2, 5'd0, 12'd5, 10'd0);
        step();
        check_write("pre_rst", 10'd0, 32'h91001441, 11'd1);
        in_valid = 1'b0; reset = 1'b1;
        step();
        check("mid_rst_we",       32'(mem_we),   32'd0);
        check("mid_rst_count",    32'(count),    32'd0);
        check("mid_rst_busy",     32'(busy),     32'd0);
        check("mid_rst_done",     32'(done),     32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        reset = 1'b0;
        step();
        check("post_rst_we",   32'(mem_we), 32'd0);
        check("post_rst_busy", 32'(busy),   32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, failures);
        $finish;
    end

endmodule
